// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on both sides.
// Logic/arith ops finish in one cycle; shifts step one bit per cycle.
module seq_alu #(
    parameter int  WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [2:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic [SHW-1:0]   shamt;

    assign shamt = in1[SHW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            cnt_q   <= '0;
            op_q    <= OP_AND;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            c_q     <= c_d;
            v_q     <= v_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        c_d     = c_q;
        v_d     = v_q;
        z_d     = z_q;
        n_d     = n_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = alu_op;
                    c_d     = 1'b0;
                    v_d     = 1'b0;
                    state_d = DONE;
                    unique case (alu_op)
                        OP_AND: res_d = in0 & in1;
                        OP_OR:  res_d = in0 | in1;
                        OP_XOR: res_d = in0 ^ in1;
                        OP_ADD: begin
                            {c_d, res_d} = {1'b0, in0} + {1'b0, in1};
                            v_d = (in0[WIDTH-1] == in1[WIDTH-1])
                                && (res_d[WIDTH-1] != in0[WIDTH-1]);
                        end
                        OP_SUB: begin
                            // Bit WIDTH of the widened difference is the borrow.
                            {c_d, res_d} = {1'b0, in0} - {1'b0, in1};
                            v_d = (in0[WIDTH-1] != in1[WIDTH-1])
                                && (res_d[WIDTH-1] != in0[WIDTH-1]);
                        end
                        OP_SLL, OP_SRL, OP_SRA: begin
                            res_d = in0;
                            if (shamt != '0) begin
                                cnt_d   = shamt;
                                state_d = SHIFT;
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                case (op_q)
                    OP_SLL: begin
                        c_d   = res_q[WIDTH-1];
                        res_d = {res_q[WIDTH-2:0], 1'b0};
                    end
                    OP_SRL: begin
                        c_d   = res_q[0];
                        res_d = {1'b0, res_q[WIDTH-1:1]};
                    end
                    default: begin
                        c_d   = res_q[0];
                        res_d = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
                    end
                endcase
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // z/n only track the final result, not intermediate shift steps.
        if (state_d == DONE && state_q != DONE) begin
            z_d = (res_d == '0);
            n_d = res_d[WIDTH-1];
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out       = res_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu with directed and random ops.
module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in0 = '0;
    logic [W-1:0] in1 = '0;
    logic [2:0]   alu_op = 3'd0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out;
    logic         flag_z, flag_n, flag_c, flag_v, busy;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .alu_op(alu_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out),
        .flag_z(flag_z), .flag_n(flag_n),
        .flag_c(flag_c), .flag_v(flag_v),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        int c;
        int v;
        int z;
        int n;
        int lat;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   seen = 0;
    bit   rnd_on = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input int op);
        exp_t e;
        int sa, sbv, s, sh;
        sa  = (a >= 128) ? a - 256 : a;
        sbv = (b >= 128) ? b - 256 : b;
        sh  = b % W;
        e.c = 0;
        e.v = 0;
        e.lat = 1;
        e.acc = 0;
        case (op)
            0: s = a & b;
            1: s = a | b;
            2: s = a ^ b;
            3: begin
                s = a + b;
                e.c = (s > 255) ? 1 : 0;
                e.v = ((sa + sbv) > 127 || (sa + sbv) < -128) ? 1 : 0;
            end
            4: begin
                s = a - b;
                e.c = (a < b) ? 1 : 0;
                e.v = ((sa - sbv) > 127 || (sa - sbv) < -128) ? 1 : 0;
            end
            5: begin
                s = a << sh;
                e.c = (sh > 0) ? ((a >> (W - sh)) & 1) : 0;
            end
            6: begin
                s = a >> sh;
                e.c = (sh > 0) ? ((a >> (sh - 1)) & 1) : 0;
            end
            default: begin
                s = sa >>> sh;
                e.c = (sh > 0) ? ((a >> (sh - 1)) & 1) : 0;
            end
        endcase
        if (op >= 5 && sh > 0) e.lat = sh + 1;
        e.res = s & 255;
        e.z = (e.res == 0) ? 1 : 0;
        e.n = (e.res >= 128) ? 1 : 0;
        return e;
    endfunction

    // Monitor: checks every presented result against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            sb.delete();
            seen = 0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("stale_result", 1, 0);
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        chk("latency", cyc - e.acc, e.lat);
                        seen = 1;
                    end
                    chk("out", int'(out), e.res);
                    chk("flag_c", int'(flag_c), e.c);
                    chk("flag_v", int'(flag_v), e.v);
                    chk("flag_z", int'(flag_z), e.z);
                    chk("flag_n", int'(flag_n), e.n);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                e = model(int'(in0), int'(in1), int'(alu_op));
                e.acc = cyc;
                sb.push_back(e);
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rnd_on) out_ready = ($urandom % 4) != 0;
    end

    task automatic issue(input int op, input int a, input int b);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        alu_op = 3'(op);
        in0 = W'(a);
        in1 = W'(b);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string nm, input int eo,
                               input int ec, input int ev);
        bit ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
            chk({nm, "_busy"}, int'(busy), 1);
        end
        if (!ok) chk({nm, "_timeout"}, 0, 1);
        chk({nm, "_out"}, int'(out), eo);
        chk({nm, "_c"}, int'(flag_c), ec);
        chk({nm, "_v"}, int'(flag_v), ev);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit drained;
        int g;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out", int'(out), 0);
        chk("rst_flags", int'({flag_z, flag_n, flag_c, flag_v}), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;

        issue(3, 'hF0, 'hAA);
        wait_result("add_f0_aa", 'h9A, 1, 0);
        chk("add_f0_aa_n", int'(flag_n), 1);
        issue(4, 'hF0, 'hAA);
        wait_result("sub_f0_aa", 'h46, 0, 0);
        issue(4, 'h80, 'h01);
        wait_result("sub_80_01", 'h7F, 0, 1);
        issue(3, 'h7F, 'h01);
        wait_result("add_7f_01", 'h80, 0, 1);
        issue(7, 'h9F, 'h04);
        wait_result("sra_9f_4", 'hF9, 1, 0);
        issue(6, 'h1F, 'h04);
        wait_result("srl_1f_4", 'h01, 1, 0);
        issue(5, 'h05, 'h08);
        wait_result("sll_05_0", 'h05, 0, 0);
        issue(0, 'h02, 'h02);
        wait_result("and_02", 'h02, 0, 0);
        issue(2, 'hAA, 'hAA);
        wait_result("xor_aa", 'h00, 0, 0);
        chk("xor_aa_z", int'(flag_z), 1);

        out_ready = 1'b0;
        issue(3, 'h12, 'h34);
        fork
            issue(2, 'h0F, 'hF0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", int'(in_ready), 0);
                    chk("bp_out_valid", int'(out_valid), 1);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_result("bp_xor", 'hFF, 0, 0);

        issue(5, 'h01, 'h07);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out", int'(out), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_flag_c", int'(flag_c), 0);
        repeat (10) @(posedge clk);
        #1;

        rnd_on = 1;
        for (int k = 0; k < 300; k++) begin
            g = $urandom % 3;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            issue($urandom % 8, $urandom % 256, $urandom % 256);
        end
        rnd_on = 0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drained = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                drained = 1;
                break;
            end
        end
        chk("drain", int'(drained), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised multi-cycle ALU that succeeds the 8-bit combinational baby_alu. It has WIDTH-bit operands, eight operations and status flags. Operands arrive and results leave through valid/ready handshakes. Logic and arithmetic ops complete in one cycle; shifts run on an iterative one-bit-per-cycle shifter, so latency depends on the shift amount. The block sits between an issue stage and a writeback stage.

Parameters:
WIDTH, 8, operand/result width in bits; power of two, >= 4
SHW, $clog2(WIDTH), shift-amount field width (derived; do not override)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand/op presented
in_ready  output  1  block can accept an operation
in0  input  WIDTH  operand A
in1  input  WIDTH  operand B; for shifts only in1[SHW-1:0] is used
alu_op  input  3  000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 SLL, 110 SRL, 111 SRA
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
out  output  WIDTH  result
flag_z  output  1  result == 0
flag_n  output  1  result MSB
flag_c  output  1  carry/borrow/shift-out, see below
flag_v  output  1  signed overflow
busy  output  1  state != IDLE

Behaviour:
- One clock; reset is synchronous and active-high: the ports are named clk and rst.
- Reset on rising edge with rst=1:
  - state=IDLE, out_valid=0, out=0, all flags=0, shift counter=0.
  - rst overrides any in-flight operation; no result is emitted for it.
- The FSM has three states: IDLE, SHIFT, DONE.
- in_ready=1 only in IDLE. There is no accept in DONE, even when out_ready=1 in the same cycle.
- Accept occurs on an edge where in_valid && in_ready.
  - Operands and op are latched on that edge.
- AND/OR/XOR/ADD/SUB: the result and flags are computed from the inputs and registered on the accept edge; the FSM goes to DONE.
- SLL/SRL/SRA with shamt = in1[SHW-1:0]:
  - shamt == 0: out=in0, flag_c=0, go to DONE (same latency as logic ops).
  - shamt > 0: the working register loads in0, counter loads shamt, go to SHIFT.
- SHIFT:
  - Each edge shifts the working register by one bit:
    - SLL shifts in 0 at the LSB.
    - SRL shifts in 0 at the MSB.
    - SRA replicates the MSB.
  - flag_c takes the bit shifted out; the counter decrements.
  - On the edge where counter==1, go to DONE.
- Latency, with accept on edge E:
  - out_valid=1 after edge E for non-shift ops or shamt==0.
  - out_valid=1 after edge E+shamt for shamt>0.
- DONE:
  - out_valid=1; out and flags are held stable until an edge with out_ready=1.
  - That edge returns to IDLE and clears out_valid. out and flags keep their last values.
- Width rules: all arithmetic is modulo 2^WIDTH.
- ADD flags:
  - flag_c = carry-out of bit WIDTH-1.
  - flag_v = operands have the same sign and the result sign differs.
- SUB (in0 - in1) flags:
  - flag_c = borrow, i.e. 1 iff in0 < in1 unsigned.
  - flag_v = operands have different signs and the result sign differs from in0.
- Logic ops: flag_c=0, flag_v=0.
- Shifts: flag_v=0; flag_c = last bit shifted out.
- flag_z and flag_n always reflect the final out.
- in1 bits above SHW-1 are ignored for shifts. Operand inputs are don't-care when no accept occurs.
- An alu_op change while not in IDLE has no effect.

Test Plan:
1. WIDTH=8, ADD in0=F0 in1=AA -> after 1 edge: out_valid=1, out=9A, c=1, v=0, n=1, z=0.
2. SUB F0-AA -> out=46, c=0, v=0. SUB 80-01 -> out=7F, v=1, c=0. ADD 7F+01 -> out=80, v=1, n=1, c=0.
3. SRA in0=9F in1=04 -> busy for 4 edges, out_valid after edge E+4, out=F9, c=1. SRL 1F by 04 -> out=01, c=1.
4. SLL in0=05 in1=08 (shamt 0) -> out=05 after 1 edge, c=0. AND 02&02 -> out=02, z=0. XOR AA^AA -> out=00, z=1.
5. Backpressure: hold out_ready=0 for 3 cycles after a result while in_valid=1 with a new op -> out/flags stable, in_ready=0, new op not accepted. Raise out_ready -> IDLE next edge, then accept.
6. Reset mid-shift: SLL 01 by 7, assert rst on the 3rd SHIFT edge -> out_valid=0, out=00, in_ready=1 next cycle, no stale result ever asserted.
